// File: rtl/timer_mc_pkg.sv
// Shared types and defaults for the multi-channel timer.
// Imported by the interface, the capture channel and the core.
package timer_mc_pkg;

    localparam int DEF_CNT_W  = 32;
    localparam int DEF_PRE_W  = 16;
    localparam int DEF_NUM_CH = 4;

    typedef enum logic [1:0] {
        MODE_ONESHOT_DN = 2'd0,
        MODE_REPEAT_DN  = 2'd1,
        MODE_REPEAT_UP  = 2'd2,
        MODE_CENTER     = 2'd3
    } cnt_mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    function automatic logic reload_down(input cnt_mode_e m);
        return (m == MODE_ONESHOT_DN) || (m == MODE_REPEAT_DN);
    endfunction

endpackage

// File: rtl/timer_mc_if.sv
// Configuration and status bundle between the register front-end
// (master) and the timer core (slave).
interface timer_mc_if
    import timer_mc_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PRE_W  = DEF_PRE_W,
    parameter int NUM_CH = DEF_NUM_CH
);
    logic                    en;
    logic [1:0]              cnt_mode;
    logic [PRE_W-1:0]        pre_val;
    logic [CNT_W-1:0]        period;
    logic                    load_cmd;
    logic [NUM_CH*CNT_W-1:0] ch_cmp;
    logic [NUM_CH-1:0]       ch_pol;
    logic [NUM_CH-1:0]       ch_pwm_en;
    logic [NUM_CH-1:0]       capture_i;
    logic [NUM_CH-1:0]       cap_ack;
    logic [CNT_W-1:0]        current_val;
    logic [NUM_CH*CNT_W-1:0] cap_val;
    logic [NUM_CH-1:0]       cap_stb;
    logic [NUM_CH-1:0]       cap_ovr;
    logic [NUM_CH-1:0]       pwm_o;
    logic                    upd_o;
    logic                    irq;

    modport master (
        output en, cnt_mode, pre_val, period, load_cmd,
        output ch_cmp, ch_pol, ch_pwm_en, capture_i, cap_ack,
        input  current_val, cap_val, cap_stb, cap_ovr,
        input  pwm_o, upd_o, irq
    );

    modport slave (
        input  en, cnt_mode, pre_val, period, load_cmd,
        input  ch_cmp, ch_pol, ch_pwm_en, capture_i, cap_ack,
        output current_val, cap_val, cap_stb, cap_ovr,
        output pwm_o, upd_o, irq
    );

endinterface

// File: rtl/timer_mc_capture.sv
// One input-capture channel: 2-flop synchroniser, rising-edge detect,
// latched counter value with strobe, pending and sticky overrun.
module timer_mc_capture
    import timer_mc_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_i,
    input  logic             ack_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] val_o,
    output logic             stb_o,
    output logic             ovr_o
);

    logic             s1_q, s2_q, prev_q;
    logic             pend_q, ovr_q, stb_q;
    logic [CNT_W-1:0] val_q;
    logic             rise;

    assign rise = s2_q & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            stb_q  <= 1'b0;
            val_q  <= '0;
        end else begin
            s1_q   <= cap_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            stb_q  <= rise;
            if (rise) begin
                val_q  <= cnt_i;
                pend_q <= 1'b1;
                // an ack in the same cycle clears the overrun but not pending
                ovr_q  <= ack_i ? 1'b0 : (ovr_q | pend_q);
            end else if (ack_i) begin
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
        end
    end

    assign val_o = val_q;
    assign stb_o = stb_q;
    assign ovr_o = ovr_q;

endmodule

// File: rtl/timer_mc_core.sv
// Shared prescaled counter with four counting modes driving NUM_CH
// double-buffered PWM compare and input-capture channels.
module timer_mc_core
    import timer_mc_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PRE_W  = DEF_PRE_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input logic      clk,
    input logic      rst_n,
    timer_mc_if.slave bus
);

    cnt_mode_e                    mode;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [PRE_W-1:0]             pre_q, pre_d;
    dir_e                         dir_q, dir_d;
    logic                         done_q, done_d;
    logic                         upd_q, evt, tick;
    logic [NUM_CH-1:0][CNT_W-1:0] cmp_q, cmp_in;
    logic [NUM_CH-1:0]            pwm_q, pwm_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cap_val_w;
    logic [NUM_CH-1:0]            cap_stb_w, cap_ovr_w;

    assign mode   = cnt_mode_e'(bus.cnt_mode);
    assign cmp_in = bus.ch_cmp;
    // >= keeps the prescaler from running away if pre_val shrinks
    assign tick   = bus.en && (pre_q >= bus.pre_val);

    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        dir_d  = dir_q;
        done_d = done_q;
        evt    = 1'b0;
        if (bus.load_cmd) begin
            pre_d  = '0;
            dir_d  = DIR_UP;
            done_d = 1'b0;
            cnt_d  = reload_down(mode) ? bus.period : '0;
        end else if (bus.en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                unique case (mode)
                    MODE_ONESHOT_DN: begin
                        if (!done_q) begin
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - 1'b1;
                            end else begin
                                evt    = 1'b1;
                                done_d = 1'b1;
                            end
                        end
                    end
                    MODE_REPEAT_DN: begin
                        if (cnt_q == '0) begin
                            evt   = 1'b1;
                            cnt_d = bus.period;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    MODE_REPEAT_UP: begin
                        if (cnt_q >= bus.period) begin
                            evt   = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    MODE_CENTER: begin
                        if (bus.period == '0) begin
                            evt   = 1'b1;
                            cnt_d = '0;
                            dir_d = DIR_UP;
                        end else if (dir_q == DIR_UP) begin
                            if (cnt_q >= bus.period) begin
                                dir_d = DIR_DN;
                                cnt_d = cnt_q - 1'b1;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else if (cnt_q == '0) begin
                            evt   = 1'b1;
                            dir_d = DIR_UP;
                            cnt_d = CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = bus.ch_pwm_en[i]
                     ? ((cnt_q < cmp_q[i]) ^ bus.ch_pol[i])
                     : bus.ch_pol[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            dir_q  <= DIR_UP;
            done_q <= 1'b0;
            upd_q  <= 1'b0;
            cmp_q  <= '0;
            pwm_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            dir_q  <= dir_d;
            done_q <= done_d;
            upd_q  <= evt;
            pwm_q  <= pwm_d;
            // compares only move at a period boundary or on load
            if (bus.load_cmd || evt) begin
                cmp_q <= cmp_in;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cap
        timer_mc_capture #(
            .CNT_W (CNT_W)
        ) u_cap (
            .clk   (clk),
            .rst_n (rst_n),
            .cap_i (bus.capture_i[g]),
            .ack_i (bus.cap_ack[g]),
            .cnt_i (cnt_q),
            .val_o (cap_val_w[g]),
            .stb_o (cap_stb_w[g]),
            .ovr_o (cap_ovr_w[g])
        );
    end

    assign bus.current_val = cnt_q;
    assign bus.cap_val     = cap_val_w;
    assign bus.cap_stb     = cap_stb_w;
    assign bus.cap_ovr     = cap_ovr_w;
    assign bus.pwm_o       = pwm_q;
    assign bus.upd_o       = upd_q;
    assign bus.irq         = upd_q | (|cap_stb_w);

endmodule

// File: tb/tb_timer_mc_core.sv
// Scoreboard bench for timer_mc_core: expectations are queued as each
// cycle is driven and popped against the outputs after the edge.
module tb_timer_mc_core;

    localparam int CW = 16;
    localparam int PW = 8;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_mc_if #(.CNT_W(CW), .PRE_W(PW), .NUM_CH(NC)) bus ();

    timer_mc_core #(
        .CNT_W  (CW),
        .PRE_W  (PW),
        .NUM_CH (NC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   t     = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underrun", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, act, e.v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic load();
        bus.load_cmd = 1'b1;
        step();
        bus.load_cmd = 1'b0;
    endtask

    // counter is a mode-1 down count from 100 started at t=0
    task automatic cap_seq(input int ch, input bit eovr);
        logic [63:0] ev;
        ev = 64'(100 - (t + 2));
        bus.capture_i[ch] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push("cap_stb", 64'(k == 3));
            push("cap_irq", 64'(k == 3));
            if (k == 3) begin
                push("cap_val", ev);
                push("cap_ovr", 64'(eovr));
            end
            step();
            pop_chk(64'(bus.cap_stb[ch]));
            pop_chk(64'(bus.irq));
            if (k == 3) begin
                pop_chk(64'(bus.cap_val[ch*CW +: CW]));
                pop_chk(64'(bus.cap_ovr[ch]));
            end
            if (k == 2) bus.capture_i[ch] = 1'b0;
        end
        repeat (2) step();
    endtask

    initial begin
        logic [CW-1:0] m_cnt, m_cmp, cmp_in, prev;
        bit            upd;
        int            ev_cnt, idx, p, v;

        bus.en        = 1'b0;
        bus.cnt_mode  = 2'd0;
        bus.pre_val   = '0;
        bus.period    = '0;
        bus.load_cmd  = 1'b0;
        bus.ch_cmp    = '0;
        bus.ch_pol    = '0;
        bus.ch_pwm_en = '0;
        bus.capture_i = '0;
        bus.cap_ack   = '0;

        #2;
        chk("rst_cnt", 64'(bus.current_val), 64'd0);
        chk("rst_pwm", 64'(bus.pwm_o), 64'd0);
        chk("rst_upd", 64'(bus.upd_o), 64'd0);
        chk("rst_irq", 64'(bus.irq), 64'd0);
        chk("rst_stb", 64'(bus.cap_stb), 64'd0);
        chk("rst_ovr", 64'(bus.cap_ovr), 64'd0);
        chk("rst_val", 64'(bus.cap_val), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // one-shot down, period 10
        bus.cnt_mode = 2'd0;
        bus.period   = 10;
        load();
        chk("m0_load", 64'(bus.current_val), 64'd10);
        bus.en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            push("m0_cnt", (k >= 10) ? 64'd0 : 64'(10 - k));
            push("m0_upd", 64'(k == 11));
            push("m0_irq", 64'(k == 11));
            step();
            pop_chk(64'(bus.current_val));
            pop_chk(64'(bus.upd_o));
            pop_chk(64'(bus.irq));
        end
        ev_cnt = 0;
        repeat (50) begin
            step();
            ev_cnt += int'(bus.upd_o | bus.irq);
        end
        chk("m0_quiet", 64'(ev_cnt), 64'd0);
        chk("m0_hold", 64'(bus.current_val), 64'd0);

        // repeat up, period 19, ch0 compare 10 then 5 mid-period
        bus.en        = 1'b0;
        bus.cnt_mode  = 2'd2;
        bus.period    = 19;
        bus.ch_cmp    = '0;
        bus.ch_cmp[0 +: CW] = 10;
        cmp_in        = 10;
        bus.ch_pwm_en = 4'b0001;
        bus.ch_pol    = '0;
        load();
        m_cnt  = 0;
        m_cmp  = 10;
        bus.en = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            prev  = m_cnt;
            upd   = (prev == 19);
            m_cnt = upd ? '0 : prev + 1'b1;
            push("m2_cnt", 64'(m_cnt));
            push("m2_upd", 64'(upd));
            push("m2_pwm", 64'(prev < m_cmp));
            if (upd) m_cmp = cmp_in;
            step();
            pop_chk(64'(bus.current_val));
            pop_chk(64'(bus.upd_o));
            pop_chk(64'(bus.pwm_o[0]));
            if (k == 5) begin
                cmp_in = 5;
                bus.ch_cmp[0 +: CW] = 5;
            end
        end

        // centre-aligned, period 4, tick every 4 cycles
        bus.en        = 1'b0;
        bus.cnt_mode  = 2'd3;
        bus.period    = 4;
        bus.pre_val   = 3;
        bus.ch_pwm_en = '0;
        load();
        bus.en = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            idx = k / 4;
            p   = idx % 8;
            v   = (p <= 4) ? p : 8 - p;
            push("m3_cnt", 64'(v));
            push("m3_upd", 64'((k % 4 == 0) && (p == 1) && (idx >= 9)));
            step();
            pop_chk(64'(bus.current_val));
            pop_chk(64'(bus.upd_o));
        end

        // capture on ch2 while repeat-down from 100
        bus.en       = 1'b0;
        bus.cnt_mode = 2'd1;
        bus.period   = 100;
        bus.pre_val  = 0;
        load();
        bus.en = 1'b1;
        t = 0;
        repeat (2) step();
        cap_seq(2, 1'b0);
        cap_seq(2, 1'b1);
        step();
        chk("ovr_sticky", 64'(bus.cap_ovr[2]), 64'd1);
        bus.cap_ack[2] = 1'b1;
        step();
        bus.cap_ack[2] = 1'b0;
        chk("ovr_ack", 64'(bus.cap_ovr[2]), 64'd0);
        cap_seq(2, 1'b0);

        // polarity and compare extremes
        bus.en        = 1'b0;
        bus.cnt_mode  = 2'd2;
        bus.period    = 19;
        bus.ch_cmp    = '0;
        bus.ch_cmp[1*CW +: CW] = 0;
        bus.ch_cmp[2*CW +: CW] = 20;
        bus.ch_cmp[3*CW +: CW] = 7;
        bus.ch_pol    = 4'b1110;
        bus.ch_pwm_en = 4'b0110;
        load();
        step();
        bus.en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            push("pol_pwm", 64'b1010);
            step();
            pop_chk(64'(bus.pwm_o));
        end

        // asynchronous reset with a capture in the synchroniser
        bus.capture_i[0] = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("ar_cnt", 64'(bus.current_val), 64'd0);
        chk("ar_pwm", 64'(bus.pwm_o), 64'd0);
        chk("ar_irq", 64'(bus.irq), 64'd0);
        chk("ar_stb", 64'(bus.cap_stb), 64'd0);
        chk("ar_ovr", 64'(bus.cap_ovr), 64'd0);
        chk("ar_val", 64'(bus.cap_val), 64'd0);
        bus.capture_i[0] = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        ev_cnt = 0;
        repeat (10) begin
            step();
            ev_cnt += int'(|bus.cap_stb);
        end
        chk("ar_no_stale", 64'(ev_cnt), 64'd0);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
